// File: rtl/registrador_pkg.sv
// registrador_pkg: shared state, mode and seven-segment constants for the register slice
package registrador_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic MODE_SERIAL = 1'b0;
  localparam logic MODE_PAR = 1'b1;
  localparam logic [7:0] NUM_0 = 8'h3F;
  localparam logic [7:0] NUM_1 = 8'h06;
  localparam logic [7:0] NUM_2 = 8'h5B;
  localparam logic [7:0] NUM_3 = 8'h4F;
  localparam logic [7:0] NUM_4 = 8'h66;
  localparam logic [7:0] NUM_5 = 8'h6D;
  localparam logic [7:0] NUM_6 = 8'h7D;
  localparam logic [7:0] NUM_7 = 8'h07;
  localparam logic [7:0] NUM_8 = 8'h7F;
  localparam logic [7:0] NUM_9 = 8'h6F;
endpackage

// File: rtl/registrador_dp.sv
// registrador_dp: load/shift register with clear, parallel load and MSB-first shift-in
module registrador_dp #(
  parameter int NBITS_REG = 4,
  parameter logic [NBITS_REG-1:0] RESET_REG = '0
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 serial_in,
  input  logic [NBITS_REG-1:0] par_in,
  output logic [NBITS_REG-1:0] q
);
  always_ff @(posedge clk_2 or negedge reset)
    if (!reset) q <= RESET_REG;
    else q <= clr ? RESET_REG : load ? par_in : shift ? {q[NBITS_REG-2:0], serial_in} : q;
endmodule

// File: rtl/registrador_seq_ctrl.sv
// registrador_seq_ctrl: start/mode sequencer driving the load/shift register through load or serial shift
module registrador_seq_ctrl import registrador_pkg::*; #(
  parameter int NBITS_REG = 4,
  parameter logic [NBITS_REG-1:0] RESET_REG = '0,
  localparam int CNT_W = $clog2(NBITS_REG)
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 abort,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 serial_in,
  input  logic [NBITS_REG-1:0] par_in,
  output logic [NBITS_REG-1:0] q,
  output logic                 ser_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bit_cnt,
  output logic [1:0]           state_o
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic load, shift;
  registrador_dp #(.NBITS_REG(NBITS_REG), .RESET_REG(RESET_REG)) u_dp (
    .clk_2(clk_2), .reset(reset), .clr(clr), .load(load), .shift(shift),
    .serial_in(serial_in), .par_in(par_in), .q(q)
  );
  always_ff @(posedge clk_2 or negedge reset)
    if (!reset) begin
      state <= IDLE;
      bit_cnt <= '0;
    end else begin
      state <= state_n;
      bit_cnt <= cnt_n;
    end
  // clr outranks abort and shifting: in SHIFT it freezes state and counter for that cycle
  always_comb begin
    state_n = IDLE;
    cnt_n = '0;
    load = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE: begin
        load = start && !clr && mode == MODE_PAR;
        state_n = (start && !clr) ? (mode == MODE_PAR ? DONE : SHIFT) : IDLE;
      end
      SHIFT: begin
        shift = !clr && !abort && shift_en;
        state_n = clr ? SHIFT : abort ? IDLE :
                  (shift_en && bit_cnt == CNT_W'(NBITS_REG-1)) ? DONE : SHIFT;
        cnt_n = clr ? bit_cnt : abort ? '0 :
                shift_en ? (bit_cnt == CNT_W'(NBITS_REG-1) ? '0 : bit_cnt + 1'b1) : bit_cnt;
      end
      default: state_n = IDLE;
    endcase
  end
  assign ser_out = q[NBITS_REG-1];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign state_o = state;
endmodule

// File: tb/tb_registrador_seq_ctrl.sv
// tb_registrador_seq_ctrl: directed and random checks of the sequencer against a transaction-level model
module tb_registrador_seq_ctrl;
  localparam int N = 4;
  logic clk_2 = 1'b0, reset = 1'b0;
  logic start = 0, mode = 0, abort = 0, clr = 0, shift_en = 0, serial_in = 0;
  logic [N-1:0] par_in = '0, q;
  logic ser_out, busy, done;
  logic [1:0] bit_cnt, state_o;
  int checks = 0, failures = 0;
  logic [N-1:0] m_q = '0;
  int m_left = 0;
  bit m_done = 0;
  int busy_cnt, done_cnt;

  registrador_seq_ctrl dut (
    .clk_2(clk_2), .reset(reset), .start(start), .mode(mode), .abort(abort), .clr(clr),
    .shift_en(shift_en), .serial_in(serial_in), .par_in(par_in), .q(q), .ser_out(ser_out),
    .busy(busy), .done(done), .bit_cnt(bit_cnt), .state_o(state_o)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q"}, 32'(q), 32'(m_q));
    chk({tag, "_ser"}, 32'(ser_out), 32'(m_q[N-1]));
    chk({tag, "_busy"}, 32'(busy), 32'(m_done || m_left > 0));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_cnt"}, 32'(bit_cnt), m_left > 0 ? 32'(N - m_left) : 32'd0);
    chk({tag, "_st"}, 32'(state_o), m_done ? 32'd2 : m_left > 0 ? 32'd1 : 32'd0);
  endtask

  // one operation is either a one-edge load or N enabled shift edges, then one done cycle
  task automatic model_edge();
    bit was_done = m_done;
    m_done = 0;
    if (clr) m_q = '0;
    if (!was_done && !clr) begin
      if (m_left == 0) begin
        if (start && mode) begin
          m_q = par_in;
          m_done = 1;
        end else if (start) m_left = N;
      end else if (abort) m_left = 0;
      else if (shift_en) begin
        m_q = {m_q[N-2:0], serial_in};
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end
  endtask

  task automatic cyc(input string tag, input logic st, input logic md, input logic ab,
                     input logic cl, input logic en, input logic si, input logic [N-1:0] pi);
    start = st; mode = md; abort = ab; clr = cl; shift_en = en; serial_in = si; par_in = pi;
    model_edge();
    @(posedge clk_2);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    logic [3:0] bits;
    logic [6:0] en_pat;
    #1;
    check_all("rst0");
    #5 reset = 1'b1;
    idle("idle0");

    cyc("t1_start", 1, 0, 0, 0, 0, 0, '0);
    cyc("t1_s0", 0, 0, 0, 0, 1, 1, '0);
    cyc("t1_s1", 0, 0, 0, 0, 1, 1, '0);
    #2 reset = 1'b0;
    m_q = '0; m_left = 0; m_done = 0;
    #1;
    check_all("t1_async");
    #1 reset = 1'b1;

    bits = 4'b1011;
    busy_cnt = 0; done_cnt = 0;
    cyc("t2_start", 1, 0, 0, 0, 0, 0, '0);
    busy_cnt += int'(busy);
    for (int i = 3; i >= 0; i--) begin
      cyc("t2_shift", 0, 0, 0, 0, 1, bits[i], '0);
      busy_cnt += int'(busy); done_cnt += int'(done);
    end
    idle("t2_after");
    busy_cnt += int'(busy); done_cnt += int'(done);
    chk("t2_q", 32'(q), 32'hB);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("t2_done_cycles", 32'(done_cnt), 32'd1);

    cyc("t3_preload", 1, 1, 0, 0, 0, 0, 4'hC);
    idle("t3_idle");
    chk("t3_preq", 32'(q), 32'hC);
    cyc("t3_load", 1, 1, 0, 0, 0, 0, 4'h9);
    chk("t3_q", 32'(q), 32'h9);
    chk("t3_done", 32'(done), 32'd1);
    cyc("t3_ignored", 1, 1, 0, 0, 0, 0, 4'h5);
    chk("t3_q_kept", 32'(q), 32'h9);
    chk("t3_st", 32'(state_o), 32'd0);

    en_pat = 7'b1011001;
    cyc("t4_start", 1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 7; i++) cyc("t4_step", 0, 0, 0, 0, en_pat[i], 1, '0);
    chk("t4_q", 32'(q), 32'hF);
    chk("t4_done", 32'(done), 32'd1);
    idle("t4_after");

    cyc("t5_clr", 0, 0, 0, 1, 0, 0, '0);
    cyc("t5_start", 1, 0, 0, 0, 0, 0, '0);
    cyc("t5_s0", 0, 0, 0, 0, 1, 1, '0);
    cyc("t5_s1", 0, 0, 0, 0, 1, 0, '0);
    cyc("t5_s2", 0, 0, 0, 0, 1, 1, '0);
    chk("t5_partial", 32'(q), 32'h5);
    cyc("t5_abort", 0, 0, 1, 0, 1, 1, '0);
    chk("t5_q", 32'(q), 32'h5);
    chk("t5_st", 32'(state_o), 32'd0);
    chk("t5_cnt", 32'(bit_cnt), 32'd0);
    idle("t5_nodone");
    chk("t5_done", 32'(done), 32'd0);

    cyc("t6_pre", 1, 1, 0, 0, 0, 0, 4'hA);
    idle("t6_idle");
    cyc("t6_clr_start", 1, 1, 0, 1, 0, 0, 4'h7);
    chk("t6_q", 32'(q), 32'h0);
    chk("t6_st", 32'(state_o), 32'd0);
    cyc("t6_start", 1, 0, 0, 0, 0, 0, '0);
    cyc("t6_s0", 0, 0, 0, 0, 1, 1, '0);
    cyc("t6_s1", 0, 0, 0, 0, 1, 1, '0);
    cyc("t6_clr_shift", 0, 0, 1, 1, 1, 1, '0);
    chk("t6_shift_q", 32'(q), 32'h0);
    chk("t6_shift_cnt", 32'(bit_cnt), 32'd2);
    chk("t6_shift_st", 32'(state_o), 32'd1);
    cyc("t6_s2", 0, 0, 0, 0, 1, 1, '0);
    chk("t6_resume_cnt", 32'(bit_cnt), 32'd3);
    cyc("t6_s3", 0, 0, 0, 0, 1, 0, '0);
    chk("t6_final_q", 32'(q), 32'h2);
    idle("t6_after");

    for (int i = 0; i < 600; i++)
      cyc("rnd", 1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
          4'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
